// File: rtl/word_rotate_ctrl.sv
// rtl/word_rotate_ctrl.sv - three-character word rotator with prescaled auto step and manual step
module word_rotate_ctrl #(
    parameter int TICKS = 50000000,
    parameter int CW    = 26
) (
    input  logic       CLOCK_50,
    input  logic       Resetn,
    input  logic [5:0] Data,
    input  logic       Load,
    input  logic       Run,
    input  logic       Dir,
    input  logic       Step,
    output logic [1:0] Sel,
    output logic [1:0] C2,
    output logic [1:0] C1,
    output logic [1:0] C0,
    output logic       Tick
);

    localparam logic [CW-1:0] LAST = CW'(TICKS - 1);
    localparam logic [CW-1:0] ONE  = CW'(1);

    logic [CW-1:0] cnt;
    logic          step_q;
    logic [1:0]    r0;
    logic [1:0]    r1;
    logic [1:0]    r2;
    logic [1:0]    sel_next;
    logic          wrap;
    logic          step_ev;
    logic          advance;

    // Load overrides everything, so wrap and step only matter when Load is low
    assign wrap    = Run && (cnt == LAST);
    assign step_ev = Step && !step_q;
    assign advance = wrap || (!Run && step_ev);

    // Prescaler: counts while running, holds while paused, cleared by Load
    always_ff @(posedge CLOCK_50 or negedge Resetn) begin
        if (!Resetn) begin
            cnt <= '0;
        end else if (Load) begin
            cnt <= '0;
        end else if (Run) begin
            cnt <= wrap ? '0 : cnt + ONE;
        end
    end

    // Tick is the registered wrap strobe, suppressed on a Load edge
    always_ff @(posedge CLOCK_50 or negedge Resetn) begin
        if (!Resetn) begin
            Tick <= 1'b0;
        end else begin
            Tick <= wrap && !Load;
        end
    end

    // Step history runs every cycle so a Step held through Load never fires
    always_ff @(posedge CLOCK_50 or negedge Resetn) begin
        if (!Resetn) begin
            step_q <= 1'b0;
        end else begin
            step_q <= Step;
        end
    end

    // Character registers captured on Load
    always_ff @(posedge CLOCK_50 or negedge Resetn) begin
        if (!Resetn) begin
            r0 <= 2'b00;
            r1 <= 2'b00;
            r2 <= 2'b00;
        end else if (Load) begin
            r0 <= Data[1:0];
            r1 <= Data[3:2];
            r2 <= Data[5:4];
        end
    end

    // Rotation index state register
    always_ff @(posedge CLOCK_50 or negedge Resetn) begin
        if (!Resetn) begin
            Sel <= 2'b00;
        end else begin
            Sel <= sel_next;
        end
    end

    // Next rotation index: Load, then illegal-state recovery, then advance
    always_comb begin
        sel_next = Sel;
        if (Load) begin
            sel_next = 2'b00;
        end else if (Sel == 2'b11) begin
            sel_next = 2'b00;
        end else if (advance) begin
            case ({Dir, Sel})
                3'b0_00: sel_next = 2'b01;
                3'b0_01: sel_next = 2'b10;
                3'b0_10: sel_next = 2'b00;
                3'b1_00: sel_next = 2'b10;
                3'b1_10: sel_next = 2'b01;
                3'b1_01: sel_next = 2'b00;
                default: sel_next = 2'b00;
            endcase
        end
    end

    // Character mux driven straight from the registered index
    always_comb begin
        C2 = r2;
        C1 = r1;
        C0 = r0;
        case (Sel)
            2'b01: begin
                C2 = r1;
                C1 = r0;
                C0 = r2;
            end
            2'b10: begin
                C2 = r0;
                C1 = r2;
                C0 = r1;
            end
            default: begin
                C2 = r2;
                C1 = r1;
                C0 = r0;
            end
        endcase
    end

endmodule

// File: tb/tb_word_rotate_ctrl.sv
// tb/tb_word_rotate_ctrl.sv - scoreboard bench for word_rotate_ctrl with TICKS=4
module tb_word_rotate_ctrl;

    logic       clk;
    logic       resetn;
    logic [5:0] data;
    logic       load;
    logic       run;
    logic       dir;
    logic       step;
    logic [1:0] sel;
    logic [1:0] c2;
    logic [1:0] c1;
    logic [1:0] c0;
    logic       tick;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    int m;
    int p;

    typedef struct {
        int         cyc;
        logic [1:0] sel;
        logic [5:0] c;
    } exp_t;

    exp_t sb[$];

    word_rotate_ctrl #(.TICKS(4), .CW(3)) dut (
        .CLOCK_50(clk),
        .Resetn  (resetn),
        .Data    (data),
        .Load    (load),
        .Run     (run),
        .Dir     (dir),
        .Step    (step),
        .Sel     (sel),
        .C2      (c2),
        .C1      (c1),
        .C0      (c0),
        .Tick    (tick)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push(input int c, input logic [1:0] s, input logic [5:0] w);
        exp_t e;
        e.cyc = c;
        e.sel = s;
        e.c   = w;
        sb.push_back(e);
    endtask

    task automatic wait_to(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    // Monitor: every Tick must match the next queued expectation
    always @(negedge clk) begin
        if (resetn && tick) begin
            if (sb.size() == 0) begin
                chk("unexpected_tick", 1, 0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("tick_cycle", cyc, e.cyc);
                chk("tick_sel", int'(sel), int'(e.sel));
                chk("tick_chars", int'({c2, c1, c0}), int'(e.c));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        resetn = 1'b0;
        data   = 6'b0;
        load   = 1'b0;
        run    = 1'b0;
        dir    = 1'b0;
        step   = 1'b0;
        #1;
        chk("reset_sel", int'(sel), 0);
        chk("reset_chars", int'({c2, c1, c0}), 0);
        chk("reset_tick", int'(tick), 0);
        repeat (2) @(negedge clk);
        resetn = 1'b1;

        // Load word, then rotate forward, backward, and with mid-interval Dir changes
        @(negedge clk);
        data = 6'b10_01_00;
        load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        run  = 1'b1;
        dir  = 1'b0;
        m    = cyc;
        chk("load_sel", int'(sel), 0);
        chk("load_chars", int'({c2, c1, c0}), 6'b10_01_00);
        push(m + 4,  2'b01, 6'b01_00_10);
        push(m + 8,  2'b10, 6'b00_10_01);
        push(m + 12, 2'b00, 6'b10_01_00);
        push(m + 16, 2'b10, 6'b00_10_01);
        push(m + 20, 2'b01, 6'b01_00_10);
        push(m + 24, 2'b10, 6'b00_10_01);
        wait_to(m + 12);
        dir = 1'b1;
        wait_to(m + 14);
        dir = 1'b0;
        wait_to(m + 15);
        chk("dir_toggle_no_move", int'(sel), 0);
        dir = 1'b1;
        wait_to(m + 22);
        dir = 1'b0;
        wait_to(m + 23);
        chk("dir_change_hold", int'(sel), 1);

        // Manual stepping: held Step gives one advance
        wait_to(m + 24);
        p    = m + 24;
        run  = 1'b0;
        step = 1'b1;
        wait_to(p + 1);
        chk("step_advance", int'(sel), 0);
        wait_to(p + 5);
        chk("step_held_once", int'(sel), 0);
        step = 1'b0;
        wait_to(p + 6);
        step = 1'b1;
        wait_to(p + 7);
        chk("step_second", int'(sel), 1);
        step = 1'b0;

        // Step while running is ignored; Tick timing unchanged
        wait_to(p + 8);
        run  = 1'b1;
        step = 1'b1;
        push(p + 12, 2'b10, 6'b00_10_01);
        wait_to(p + 10);
        step = 1'b0;
        wait_to(p + 12);
        dir = 1'b1;

        // Load on the wrap edge wins; held Load keeps everything at zero
        wait_to(p + 15);
        load = 1'b1;
        data = 6'b00_11_01;
        wait_to(p + 16);
        chk("load_wrap_sel", int'(sel), 0);
        chk("load_wrap_chars", int'({c2, c1, c0}), 6'b00_11_01);
        chk("load_wrap_tick", int'(tick), 0);
        wait_to(p + 17);
        chk("load_held_sel", int'(sel), 0);
        load = 1'b0;
        push(p + 21, 2'b10, 6'b01_00_11);

        // Pause with prescaler at 2, resume: Tick two cycles later
        wait_to(p + 23);
        run = 1'b0;
        wait_to(p + 33);
        run = 1'b1;
        push(p + 35, 2'b01, 6'b11_01_00);
        wait_to(p + 35);
        dir = 1'b0;
        push(p + 39, 2'b10, 6'b01_00_11);

        // Asynchronous reset mid-count with Sel=10
        wait_to(p + 41);
        #2;
        resetn = 1'b0;
        #1;
        chk("async_reset_sel", int'(sel), 0);
        chk("async_reset_chars", int'({c2, c1, c0}), 0);
        chk("async_reset_tick", int'(tick), 0);
        #1;
        resetn = 1'b1;
        push(p + 45, 2'b01, 6'b00_00_00);

        wait_to(p + 47);
        run = 1'b0;
        repeat (3) @(negedge clk);
        chk("scoreboard_drained", sb.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
